// File: rtl/seq_mag_compare_ctrl.sv
// Sequencer that compares two WIDTH-bit operands MSB nibble first through one
// shared external 4-bit magnitude comparator slice, stopping at the first unequal nibble.
module seq_mag_compare_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    input  logic             slice_lt,
    input  logic             slice_gt,
    input  logic             slice_eq,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             err,
    output logic [1:0]       o_dbg_state
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_lt;
    logic               r_gt;
    logic               r_eq;
    logic               r_err;

    logic               w_accept;
    logic               w_idx_dec;
    logic               w_set_err;
    logic               w_set_gt;
    logic               w_set_lt;
    logic               w_set_eq;
    logic               w_onehot;
    logic [IDX_W+1:0]   w_bit_base;

    assign w_onehot = ({slice_lt, slice_gt, slice_eq} == 3'b100) ||
                      ({slice_lt, slice_gt, slice_eq} == 3'b010) ||
                      ({slice_lt, slice_gt, slice_eq} == 3'b001);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_idx_dec   = 1'b0;
        w_set_err   = 1'b0;
        w_set_gt    = 1'b0;
        w_set_lt    = 1'b0;
        w_set_eq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                // A malformed slice response wins over any decision it might imply.
                if (!w_onehot) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (slice_gt) begin
                    w_set_gt    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (slice_lt) begin
                    w_set_lt    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_idx == '0) begin
                    w_set_eq    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_dec   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_idx   <= '0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a <= a;
                r_op_b <= b;
                r_idx  <= IDX_W'(NIBBLES - 1);
                r_lt   <= 1'b0;
                r_gt   <= 1'b0;
                r_eq   <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_idx_dec) r_idx <= r_idx - 1'b1;
            if (w_set_err) r_err <= 1'b1;
            if (w_set_gt)  r_gt  <= 1'b1;
            if (w_set_lt)  r_lt  <= 1'b1;
            if (w_set_eq)  r_eq  <= 1'b1;
        end
    end

    assign w_bit_base = {r_idx, 2'b00};

    always_comb begin
        slice_a = 4'd0;
        slice_b = 4'd0;
        if (r_state == S_CMP) begin
            slice_a = r_op_a[w_bit_base +: 4];
            slice_b = r_op_b[w_bit_base +: 4];
        end
    end

    assign busy        = (r_state == S_CMP) || (r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign a_lt_b      = r_lt;
    assign a_gt_b      = r_gt;
    assign a_eq_b      = r_eq;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule
